// File: rtl/uart_ctrl.sv
// uart_ctrl: full-duplex 8N1 UART with TX and RX FIFOs.
// A shared free-running baud tick drives both the serialiser and the oversampling receiver.
`timescale 1ns/1ps
module uart_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w_en,
    input  logic       r_en,
    input  logic       rxd,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       txd
);
    localparam int OSR = BAUD_RATE * OVERSAMPLE;
    localparam int DIV = (CLK_FREQ + OSR / 2) / OSR;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;

    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [OW-1:0] OS_M1  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_MID = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] DEPTH  = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic          tick;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PW-1:0] tx_rptr_q, tx_rptr_d;
    logic          tx_full_q, tx_full_d;
    logic          tx_push, tx_pop, tx_nonempty;

    state_e        tx_state_q, tx_state_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [OW-1:0] tx_os_q, tx_os_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_bit_end;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        rx_state_q, rx_state_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [OW-1:0] rx_os_q, rx_os_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic          rx_push, rx_pop, rx_full;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PW-1:0] rx_rptr_q, rx_rptr_d;
    logic          rx_empty_q, rx_empty_d;
    logic [7:0]    data_out_q, data_out_d;

    always_comb begin
        tick       = (baud_cnt_q == DIV_M1);
        baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    always_comb begin
        tx_push     = w_en && !tx_full_q;
        tx_nonempty = (tx_wptr_q != tx_rptr_q);
        tx_wptr_d   = tx_wptr_q + PW'(tx_push);
        tx_rptr_d   = tx_rptr_q + PW'(tx_pop);
        tx_full_d   = ((tx_wptr_d - tx_rptr_d) == DEPTH);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        tx_bit_end = tick && (tx_os_q == OS_M1);
        if (tick) begin
            tx_os_d = (tx_os_q == OS_M1) ? '0 : tx_os_q + 1'b1;
        end
        unique case (tx_state_q)
            S_IDLE: tx_state_d = S_IDLE;
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_bit_end) tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Reloading at the end of the stop bit keeps queued frames back-to-back.
        if ((tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_bit_end))
            && tx_nonempty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rptr_q[AW-1:0]];
            tx_os_d    = '0;
            tx_state_d = S_START;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        if (tick) begin
            rx_os_d = (rx_os_q == OS_M1) ? '0 : rx_os_q + 1'b1;
        end
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_os_d    = '0;
                end
            end
            S_START: begin
                // Half a bit in: a line back high was only a glitch.
                if (tick && rx_os_q == OS_MID) begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick && rx_os_q == OS_M1) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && rx_os_q == OS_M1) begin
                    rx_state_d = S_IDLE;
                    rx_push    = rx_s2_q && !rx_full;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_full    = ((rx_wptr_q - rx_rptr_q) == DEPTH);
        rx_pop     = r_en && !rx_empty_q;
        rx_wptr_d  = rx_wptr_q + PW'(rx_push);
        rx_rptr_d  = rx_rptr_q + PW'(rx_pop);
        rx_empty_d = (rx_wptr_d == rx_rptr_d);
        data_out_d = rx_pop ? rx_mem_q[rx_rptr_q[AW-1:0]] : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= data_in;
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_full_q  <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_shift_q <= '0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_shift_q <= '0;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_empty_q <= 1'b1;
            data_out_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_full_q  <= tx_full_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_empty_q <= rx_empty_d;
            data_out_q <= data_out_d;
        end
    end

    assign txd = (tx_state_q == S_START) ? 1'b0 :
                 (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;
    assign data_out = data_out_q;
    assign empty    = rx_empty_q;
    assign full     = tx_full_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed bench for uart_ctrl at a scaled-down baud.
// Divisor 2 and 16x oversampling give 32 clocks (640 ns) per bit.
`timescale 1ns/1ps
module tb_uart_ctrl;
    localparam int  BIT_CYC = 32;
    localparam real BIT_NS  = 640.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       empty, full, txd;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    uart_ctrl #(
        .CLK_FREQ  (3_200_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (w_en),
        .r_en    (r_en),
        .rxd     (rxd),
        .data_in (data_in),
        .data_out(data_out),
        .empty   (empty),
        .full    (full),
        .txd     (txd)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Samples a txd frame at mid-bit once the start bit is seen.
    task automatic get_frame(output logic [7:0] b, output int t0,
                             output logic ok, input int tmo);
        int   n = 0;
        logic st, sp;
        b = '0;
        t0 = 0;
        ok = 1'b0;
        while (txd !== 1'b0 && n < tmo) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) return;
        t0 = cyc;
        repeat (BIT_CYC / 2) @(negedge clk);
        st = txd;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            b[i] = txd;
        end
        repeat (BIT_CYC) @(negedge clk);
        sp = txd;
        ok = (st == 1'b0) && (sp == 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                           input real bt);
        rxd = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bt);
        end
        rxd = stop_bit;
        #(bt);
        rxd = 1'b1;
        @(negedge clk);
    endtask

    task automatic rx_case(input string tag, input logic [7:0] b,
                           input real bt);
        chk({tag, " empty before"}, 32'(empty), 32'd1);
        send_rx(b, 1'b1, bt);
        repeat (4) @(negedge clk);
        chk({tag, " empty after frame"}, 32'(empty), 32'd0);
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        chk({tag, " data_out"}, 32'(data_out), 32'(b));
        chk({tag, " empty after pop"}, 32'(empty), 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v9 [9] = '{8'h3C, 8'h81, 8'h5A, 8'hFF, 8'h00,
                               8'h7E, 8'hC3, 8'h12, 8'hE9};
        logic [7:0] b;
        logic       ok, bad, saw_full;
        int         t, tp, tw, n;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || empty !== 1'b1 || full !== 1'b0
                || data_out !== 8'h00) bad = 1'b1;
        end
        chk("idle outputs stable", 32'(bad), 32'd0);

        // Single byte 0xA5
        tw = cyc;
        w_en = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        w_en = 1'b0;
        get_frame(b, t, ok, 4 * BIT_CYC);
        chk("a5 start delay", 32'((t - tw) <= BIT_CYC), 32'd1);
        chk("a5 framing", 32'(ok), 32'd1);
        chk("a5 byte", 32'(b), 32'hA5);
        repeat (BIT_CYC) @(negedge clk);

        // Nine bytes, back-to-back frames
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    w_en = 1'b1;
                    data_in = v9[i];
                    @(negedge clk);
                    w_en = 1'b0;
                    @(negedge clk);
                    if (full) saw_full = 1'b1;
                end
            end
            begin
                tp = 0;
                for (int i = 0; i < 9; i++) begin
                    get_frame(b, t, ok, 12 * BIT_CYC);
                    chk($sformatf("nine byte%0d", i), 32'(b), 32'(v9[i]));
                    chk($sformatf("nine framing%0d", i), 32'(ok), 32'd1);
                    if (i > 0)
                        chk($sformatf("nine gap%0d", i),
                            32'((t - tp) >= 318 && (t - tp) <= 321), 32'd1);
                    tp = t;
                end
            end
        join
        chk("nine full never", 32'(saw_full), 32'd0);
        repeat (BIT_CYC) @(negedge clk);

        // Overfill: first byte goes straight to the shifter, 16 then fill the FIFO
        fork
            begin
                w_en = 1'b1;
                data_in = 8'h10;
                for (int k = 1; k <= 16; k++) begin
                    @(negedge clk);
                    if (k == 16) chk("fill full before last", 32'(full), 32'd0);
                    data_in = 8'(8'h10 + k);
                end
                @(negedge clk);
                chk("fill full set", 32'(full), 32'd1);
                data_in = 8'hEE;
                @(negedge clk);
                w_en = 1'b0;
                chk("fill full held", 32'(full), 32'd1);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    get_frame(b, t, ok, 12 * BIT_CYC);
                    chk($sformatf("fill byte%0d", i), 32'(b), 32'(8'h10 + i));
                    chk($sformatf("fill framing%0d", i), 32'(ok), 32'd1);
                end
            end
        join
        bad = 1'b0;
        repeat (20 * BIT_CYC) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        chk("fill dropped byte not sent", 32'(bad), 32'd0);
        chk("fill full cleared", 32'(full), 32'd0);

        // Receive at nominal, +2% and -2% bit times
        rx_case("rx nominal", 8'h3C, BIT_NS);
        rx_case("rx slow", 8'h96, BIT_NS * 1.0195);
        rx_case("rx fast", 8'h3C, BIT_NS * 0.98);

        // Framing error and idle glitch
        send_rx(8'h55, 1'b0, BIT_NS);
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("ferr empty", 32'(empty), 32'd1);
        rxd = 1'b0;
        #60;
        rxd = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("glitch empty", 32'(empty), 32'd1);
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        chk("empty read data_out", 32'(data_out), 32'h3C);
        chk("empty read empty", 32'(empty), 32'd1);
        rx_case("rx recover", 8'h5A, BIT_NS);

        // Reset in the middle of a frame
        w_en = 1'b1;
        data_in = 8'h00;
        @(negedge clk);
        w_en = 1'b0;
        n = 0;
        while (txd !== 1'b0 && n < 4 * BIT_CYC) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        chk("midrst txd low", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst txd", 32'(txd), 32'd1);
        chk("midrst data_out", 32'(data_out), 32'd0);
        chk("midrst empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12 * BIT_CYC) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        chk("midrst frame aborted", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
